// File: rtl/run_sequencer.sv
// run_sequencer: launch controller that resets the core, pulses req, then times the run until done.
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset of this block
//   start       host launch request, level-sampled in IDLE/DONE
//   core_done   done output of the core
//   core_reset  active-high reset to the core
//   core_req    one-cycle req pulse to the core
//   busy        high in RESET, REQ and RUN
//   run_done    high in DONE
//   timeout     last run aborted by the RUN limit (only with RUN_TIMEOUT_EN)
//   cycle_count RUN cycles of the last or current run, saturating
// Optional macro RUN_TIMEOUT_EN enables the TIMEOUT_CYC limit on the RUN state.
module run_sequencer #(
  parameter int RST_CYCLES  = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             core_done,
  output logic             core_reset,
  output logic             core_req,
  output logic             busy,
  output logic             run_done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);
  typedef enum logic [2:0] {S_IDLE, S_RESET, S_REQ, S_RUN, S_DONE} state_t;
  state_t state;
  logic [3:0] rst_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic limit;
  assign cnt_inc = &cycle_count ? cycle_count : cycle_count + 1'b1;
`ifdef RUN_TIMEOUT_EN
  assign limit = cnt_inc == CNT_W'(TIMEOUT_CYC);
`else
  // no limit: the parameter is referenced only to keep the interface identical
  assign limit = TIMEOUT_CYC < 0;
`endif
  // outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      core_reset  <= 1'b1;
      core_req    <= 1'b0;
      busy        <= 1'b0;
      run_done    <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          state       <= S_RESET;
          rst_cnt     <= 4'(RST_CYCLES - 1);
          cycle_count <= '0;
          timeout     <= 1'b0;
          core_reset  <= 1'b1;
          busy        <= 1'b1;
          run_done    <= 1'b0;
        end
        S_RESET: if (rst_cnt == 4'd0) begin
          state      <= S_REQ;
          core_reset <= 1'b0;
          core_req   <= 1'b1;
        end else rst_cnt <= rst_cnt - 4'd1;
        // core_done is ignored here so a stale done cannot end the new run
        S_REQ: begin
          state    <= S_RUN;
          core_req <= 1'b0;
        end
        S_RUN: begin
          cycle_count <= cnt_inc;
          if (core_done || limit) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            run_done   <= 1'b1;
            timeout    <= !core_done;
            core_reset <= !core_done;
          end
        end
        default: begin
          state       <= S_IDLE;
          core_reset  <= 1'b1;
          core_req    <= 1'b0;
          busy        <= 1'b0;
          run_done    <= 1'b0;
          timeout     <= 1'b0;
          cycle_count <= '0;
        end
      endcase
    end
  end
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Upstream launch controller for the 9-bit single-cycle core. It drives the core's clk-domain reset/req pins and consumes its done output.
- On a host start it resets the core, issues one req pulse, then waits for done while counting execution cycles.
- It reports completion, cycle count and, optionally, timeout to the test harness or host.

Parameters:
- RST_CYCLES, 2, number of cycles core_reset is held high before req; legal range 1..15.
- CNT_W, 16, width of cycle_count.
- TIMEOUT_CYC, 4096, RUN-state cycle limit; used only when RUN_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset of this block.
- start  in  1  host launch request, level-sampled.
- core_done  in  1  done output of the core.
- core_reset  out  1  active-high reset to the core.
- core_req  out  1  one-cycle req pulse to the core.
- busy  out  1  high in the RESET, REQ and RUN states.
- run_done  out  1  high in the DONE state.
- timeout  out  1  high when the last run was aborted by the limit (0 if the feature is compiled out).
- cycle_count  out  CNT_W  RUN cycles of the last or current run.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, core_reset=1, core_req=0, busy=0, run_done=0, timeout=0, cycle_count=0, rst_cnt=0.
  - Release is synchronous to the next clk edge.
- All outputs are registered and decoded from state, so there are no combinational input-to-output paths.
- IDLE:
  - core_reset=1 (core parked).
  - If start=1: go to RESET, load rst_cnt=RST_CYCLES-1, clear cycle_count and timeout.
- RESET:
  - core_reset=1, busy=1.
  - When rst_cnt=0, go to REQ; otherwise decrement rst_cnt.
  - core_reset is therefore high for exactly RST_CYCLES cycles after the IDLE cycle.
- REQ:
  - core_reset=0, core_req=1 for exactly one cycle, busy=1, then go to RUN.
  - core_done is ignored here, so stale done from a previous program cannot terminate the run.
- RUN:
  - core_reset=0, core_req=0, busy=1.
  - Every RUN cycle, cycle_count increments by 1; the first RUN cycle yields 1.
  - cycle_count saturates at 2^CNT_W-1 with no wrap.
  - If core_done=1 is sampled in a RUN cycle, go to DONE. That cycle is counted.
- DONE:
  - run_done=1, busy=0, core_reset=0 (core held at final state so its memory can be inspected).
  - cycle_count is frozen.
  - If start=1: begin a new run exactly as from IDLE (go to RESET, clear count and timeout).
  - Otherwise stay in DONE.
- start in RESET, REQ or RUN is ignored. There is no queuing and no abort via start.
- Simultaneous events:
  - core_done=1 and timeout limit in the same RUN cycle: done wins, timeout=0.
  - start held high continuously gives back-to-back runs, each passing through DONE for one cycle.
- Reset asserted mid-run:
  - Immediate return to IDLE with all reset values.
  - core_reset rises asynchronously, so the core is reset too.
- Reachable state encodings: 5 states (IDLE, RESET, REQ, RUN, DONE). Any illegal encoding goes to IDLE on the next clock.

Optional Feature:
- Macro RUN_TIMEOUT_EN.
- Defined:
  - A RUN-state limit applies. When cycle_count reaches TIMEOUT_CYC while core_done=0, the next state is DONE with timeout=1 and run_done=1.
  - The core is then held in reset (core_reset=1) in DONE to stop a runaway program.
  - timeout clears on the next start or on reset.
- Undefined:
  - No limit; RUN waits indefinitely.
  - timeout is tied to 0, and TIMEOUT_CYC is unused.

Test Plan:
- Reset/basic run:
  - Stimulus: reset low 3 cycles, then high; hold start=0 for 5 cycles.
  - Required: core_reset=1, busy=0, run_done=0, cycle_count=0 throughout.
- Nominal run, RST_CYCLES=2:
  - Stimulus: pulse start for 1 cycle; core_done rises in the 10th RUN cycle.
  - Required: core_reset high 2 cycles after IDLE, core_req high exactly 1 cycle, then run_done=1, cycle_count=10, busy=0.
- Stale done:
  - Stimulus: core_done held 1 during RESET and REQ, dropped in RUN cycle 1, raised again in RUN cycle 4.
  - Required: run ends with cycle_count=4.
- Restart from DONE and start-while-busy:
  - Stimulus: start asserted in RUN cycle 3 (ignored); after DONE, pulse start.
  - Required: new RESET sequence begins, cycle_count clears to 0, run_done drops the cycle after start is sampled.
- Saturation, CNT_W=4:
  - Stimulus: core_done withheld 20 RUN cycles.
  - Required: cycle_count stops at 15.
- Async reset mid-run and timeout:
  - Stimulus: drop reset in RUN cycle 5 with no clk edge.
  - Required: core_reset=1 immediately, state IDLE.
  - Stimulus (RUN_TIMEOUT_EN defined, TIMEOUT_CYC=8): core_done never rises.
  - Required: timeout=1, run_done=1, cycle_count=8, core_reset=1.
